// File: rtl/nano_rv32i_pkg.sv
// nano_rv32i_pkg: shared encodings for the nano_rv32i data-memory path
package nano_rv32i_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    localparam int WCNT_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} dmem_state_e;
endpackage

// File: rtl/nano_rv32i_dmem_align.sv
// nano_rv32i_dmem_align: byte-lane steering, byte enables and load extension
module nano_rv32i_dmem_align
    import nano_rv32i_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);
    logic        w_byte, w_half, w_word;
    logic [4:0]  w_sh;
    logic [15:0] w_lane;
    assign w_byte = i_size == SZ_BYTE;
    assign w_half = i_size == SZ_HALF;
    assign w_word = i_size == SZ_WORD;
    assign w_sh = w_half ? {i_addr_lo[1], 4'b0000} : {i_addr_lo, 3'b000};
    assign w_lane = 16'(i_rword >> w_sh);
    assign o_be = w_byte ? 4'b0001 << i_addr_lo :
                  w_half ? 4'b0011 << {i_addr_lo[1], 1'b0} :
                  w_word ? 4'b1111 : 4'b0000;
    // replicating the store data puts it on every lane; the byte enables pick the live one
    assign o_wdata = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
    assign o_rdata = w_byte ? {{24{~i_unsigned & w_lane[7]}}, w_lane[7:0]} :
                     w_half ? {{16{~i_unsigned & w_lane[15]}}, w_lane} : i_rword;
    assign o_misalign = (w_half & i_addr_lo[0]) | (w_word & |i_addr_lo);
endmodule

// File: rtl/nano_rv32i_dmem_resp.sv
// nano_rv32i_dmem_resp: on-chip data RAM responder with wait states and fault reporting
module nano_rv32i_dmem_resp
    import nano_rv32i_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic        d_rd_i,
    input  logic        d_wr_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_unsigned_i,
    output logic [31:0] d_data_o,
    output logic        d_ready_o,
    output logic        d_err_o
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]       r_mem [DEPTH];
    dmem_state_e       r_state;
    logic [WCNT_W-1:0] r_cnt;
    logic [31:0]       r_addr, r_wdata, r_rword, r_hold;
    logic [1:0]        r_size;
    logic              r_uns, r_rd, r_wr;
    logic [31:0]       w_off_in, w_off, w_wdata, w_rdata, w_resp_data;
    logic [AW-1:0]     w_idx_in, w_idx;
    logic [3:0]        w_be;
    logic              w_misalign, w_fault, w_req, w_resp;
    assign w_off_in = d_addr_i - BASE_ADDR;
    assign w_off = r_addr - BASE_ADDR;
    assign w_idx_in = AW'(w_off_in >> 2);
    assign w_idx = AW'(w_off >> 2);
    assign w_req = d_rd_i | d_wr_i;
    assign w_resp = r_state == ST_RESP;
    assign w_fault = (r_rd & r_wr) | (r_size == SZ_RSVD) | w_misalign | ((w_off >> (AW + 2)) != 32'd0);
    assign w_resp_data = w_fault ? 32'd0 : r_rd ? w_rdata : r_hold;
    // the response cycle shows the freshly steered RAM word; otherwise the last response is held
    assign d_data_o = w_resp ? w_resp_data : r_hold;
    assign d_ready_o = w_resp;
    assign d_err_o = w_resp & w_fault;
    nano_rv32i_dmem_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_rword    (r_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt <= '0;
            r_hold <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req) begin
                    r_addr <= d_addr_i;
                    r_wdata <= d_data_i;
                    r_size <= d_size_i;
                    r_uns <= d_unsigned_i;
                    r_rd <= d_rd_i;
                    r_wr <= d_wr_i;
                    r_cnt <= WCNT_W'(WAIT_STATES);
                    r_state <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == WCNT_W'(1)) r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_hold <= w_resp_data;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    // RAM is read at accept so the registered word is ready even with zero wait states
    always_ff @(posedge clk_i) begin
        if (r_state == ST_IDLE && w_req) r_rword <= r_mem[w_idx_in];
        if (w_resp && r_wr && !w_fault && !rst_i)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
endmodule

// File: doc/nano_rv32i_dmem_resp.md
Name: nano_rv32i_dmem_resp

Overview:
Responder (slave) end of the nano_rv32i data-memory port: a word-organised on-chip RAM that services load/store requests issued by the core. It adds a ready/error handshake with a configurable number of wait states, plus byte/half/word steering and load sign-extension. It replaces the behavioural data array used in simulation and sits between the core's d_* port and the system.

Parameters:
DEPTH, 256, number of 32-bit words; power of two.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned.
WAIT_STATES, 0, extra cycles inserted between request accept and response; 0..15.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
d_addr_i  input  32  byte address of request
d_data_i  input  32  store data from core (right-aligned for SB/SH)
d_rd_i  input  1  load request
d_wr_i  input  1  store request
d_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved
d_unsigned_i  input  1  loads: 1 zero-extend, 0 sign-extend
d_data_o  output  32  load data, extended to 32 bits
d_ready_o  output  1  one-cycle response pulse
d_err_o  output  1  qualifies d_ready_o: request faulted

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE, d_ready_o=0, d_err_o=0, d_data_o=0. RAM contents are not cleared. A pending store is dropped and never committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if d_rd_i or d_wr_i is high, accept. Latch addr, data, size, unsigned and direction. Wait counter loads WAIT_STATES. Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT: decrement counter each cycle. Go to RESP on the cycle the counter reaches 1. Request inputs are ignored while busy.
- RESP: d_ready_o=1 for exactly this cycle, then IDLE. No request is accepted in RESP.
- Latency: accept at edge N, d_ready_o high in cycle N+1+WAIT_STATES. Maximum throughput is one access per WAIT_STATES+2 cycles.
- Fault checks are evaluated on latched values. If any fault is present, RESP asserts d_err_o=1, no RAM write occurs and d_data_o=0. Faults are:
  - d_rd_i and d_wr_i both high;
  - d_size_i=11;
  - misaligned access (half with addr[0]=1; word with addr[1:0]!=0);
  - address outside BASE_ADDR .. BASE_ADDR+DEPTH*4-1.
- Word index = (addr-BASE_ADDR)>>2, using log2(DEPTH) bits. Memory is little-endian.
- Store: committed at the RESP edge, using a byte-enable mask from size and addr[1:0].
  - SB writes d_data_i[7:0] to lane addr[1:0].
  - SH writes d_data_i[15:0] to lanes {addr[1],0}+1..0.
  - Unselected lanes are preserved.
- Load: RAM is read synchronously (a single-port RAM inference is acceptable). The selected lane is shifted to bit 0 and sign- or zero-extended per d_unsigned_i. Word loads ignore d_unsigned_i.
- d_data_o is registered; it updates in the RESP cycle and holds until the next RESP. Stores leave d_data_o unchanged.
- d_err_o is high only together with d_ready_o; otherwise 0.

Decomposition:
- nano_rv32i_pkg holds:
  - size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10);
  - FSM state encoding for IDLE/WAIT/RESP;
  - WAIT counter width constant (4).
- One sub-module, nano_rv32i_dmem_align (combinational):
  - inputs size, addr[1:0], unsigned, wdata, rword;
  - outputs byte-enable[3:0], lane-shifted wdata, extended rdata, misalign flag.
  - It is reusable by a future core-side LSU.

Test Plan:
- WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> d_ready_o pulses 1 cycle after each accept; d_data_o=0xDEADBEEF, d_err_o=0.
- LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
- SH 0x00001234 @0x12, then LW @0x10 -> 0x1234BEEF; SB 0x55 @0x10, then LW -> 0x1234BE55.
- LW @0x11 -> d_ready_o=1, d_err_o=1, d_data_o=0. Address BASE_ADDR+DEPTH*4 -> error. d_rd_i=d_wr_i=1 -> error, with memory unchanged on readback.
- WAIT_STATES=3: request held across accept -> d_ready_o high exactly 4 cycles after accept edge, single pulse; a second request presented during WAIT is not accepted until after RESP.
- SW 0xCAFEF00D @0x20 then rst_i during WAIT (WAIT_STATES=3) -> no d_ready_o; outputs 0 next cycle; LW @0x20 returns the prior contents.
